// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-controller R-beat serializer.
package cc_pkg;

  localparam int CC_LINE_W = 512;
  localparam int CC_BEAT_W = 64;
  localparam int CC_BEATS  = CC_LINE_W / CC_BEAT_W;
  localparam int CC_ID_W   = 4;
  localparam int CC_OFS_W  = $clog2(CC_BEATS);

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  // One buffered cache line with its AXI ID and critical-word index.
  typedef struct packed {
    logic [CC_ID_W-1:0]   id;
    logic [CC_OFS_W-1:0]  ofs;
    logic [CC_LINE_W-1:0] data;
  } cc_line_entry_t;

  // Wrapping word index: critical word first, then ascending mod CC_BEATS.
  function automatic logic [CC_OFS_W-1:0] beat_idx(input logic [CC_OFS_W-1:0] ofs,
                                                    input logic [CC_OFS_W-1:0] cnt);
    return ofs + cnt;
  endfunction

endpackage

// File: rtl/cc_rbeat_serializer_if.sv
// Line-in / R-beat-out bundle. slave = serializer view, master = producer/consumer view.
interface cc_rbeat_serializer_if #(
  parameter int ID_WIDTH   = cc_pkg::CC_ID_W,
  parameter int BEAT_WIDTH = cc_pkg::CC_BEAT_W,
  parameter int LINE_WIDTH = cc_pkg::CC_LINE_W
);
  // line side
  logic                  line_valid_i;
  logic                  line_ready_o;
  logic [ID_WIDTH-1:0]   line_id_i;
  logic [2:0]            line_ofs_i;
  logic [LINE_WIDTH-1:0] line_data_i;
  // INCT R channel
  logic [ID_WIDTH-1:0]   inct_rid_o;
  logic [BEAT_WIDTH-1:0] inct_rdata_o;
  logic [1:0]            inct_rresp_o;
  logic                  inct_rlast_o;
  logic                  inct_rvalid_o;
  logic                  inct_rready_i;

  modport slave (
    input  line_valid_i, line_id_i, line_ofs_i, line_data_i, inct_rready_i,
    output line_ready_o, inct_rid_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o
  );

  modport master (
    output line_valid_i, line_id_i, line_ofs_i, line_data_i, inct_rready_i,
    input  line_ready_o, inct_rid_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o
  );
endinterface

// File: rtl/cc_line_buf.sv
// Two-entry line FIFO: one line drains from the head while the next loads at the tail.
// ready_o is registered and reflects next-cycle occupancy < 2.
module cc_line_buf
  import cc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  cc_line_entry_t push_entry_i,
  input  logic           pop_i,
  output cc_line_entry_t head_o,
  output logic           full_o,
  output logic           empty_o,
  output logic           ready_o
);
  localparam int DEPTH = 2;

  cc_line_entry_t mem_q [DEPTH];
  logic           head_q, head_d;
  logic           tail_q, tail_d;
  logic [1:0]     occ_q, occ_d;
  logic           ready_q, ready_d;

  // Pointer/occupancy next state; simultaneous push+pop keeps occupancy.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push_i) tail_d = ~tail_q;
    if (pop_i)  head_d = ~head_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    ready_d = (occ_d < 2'd2);
  end

  // Control state; ready stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      occ_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
    end
  end

  // Line storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_o  = mem_q[head_q];
  assign full_o  = (occ_q == 2'd2);
  assign empty_o = (occ_q == 2'd0);
  assign ready_o = ready_q;

endmodule

// File: rtl/cc_rbeat_serializer.sv
// Cache-line to AXI R-burst serializer: each 512-bit line leaves as an 8-beat
// wrapping burst, critical word first, rlast on the 8th beat.
// Optional perf counters (stall/burst) are built when CC_RBEAT_PERF_EN is defined.
module cc_rbeat_serializer
  import cc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  cc_rbeat_serializer_if.slave bus
`ifdef CC_RBEAT_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] burst_cnt_o
`endif
);
  localparam logic [CC_OFS_W-1:0] LAST_BEAT = CC_OFS_W'(CC_BEATS - 1);

  cc_line_entry_t                     wr_entry, head;
  logic                               push, pop, full, empty, ready;
  logic                               rvalid, beat_hs, last_beat;
  logic [CC_OFS_W-1:0]                cnt_q, cnt_d, idx;
  logic [CC_BEATS-1:0][CC_BEAT_W-1:0] words;

  assign wr_entry = {bus.line_id_i, bus.line_ofs_i, bus.line_data_i};
  // full is redundant with ready but keeps the buffer safe on its own.
  assign push     = bus.line_valid_i && ready && !full;

  cc_line_buf u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (wr_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .ready_o      (ready)
  );

  assign rvalid    = !empty;
  assign beat_hs   = rvalid && bus.inct_rready_i;
  assign last_beat = (cnt_q == LAST_BEAT);
  assign pop       = beat_hs && last_beat;

  // Beat counter advances per handshake and restarts when the line retires.
  always_comb begin
    cnt_d = cnt_q;
    if (pop)          cnt_d = '0;
    else if (beat_hs) cnt_d = cnt_q + 1'b1;
  end

  // Beat counter register; reset drops any partial burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Outputs depend only on head/cnt, so they hold steady under backpressure.
  assign words = head.data;
  assign idx   = beat_idx(head.ofs, cnt_q);

  assign bus.line_ready_o  = ready;
  assign bus.inct_rvalid_o = rvalid;
  assign bus.inct_rid_o    = rvalid ? head.id : '0;
  assign bus.inct_rdata_o  = rvalid ? words[idx] : '0;
  assign bus.inct_rlast_o  = rvalid && last_beat;
  assign bus.inct_rresp_o  = RRESP_OKAY;

`ifdef CC_RBEAT_PERF_EN
  logic [31:0] stall_q, burst_q;

  // Saturating counters: stalled beat cycles and completed bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      burst_q <= '0;
    end else begin
      if (rvalid && !bus.inct_rready_i && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (pop && (burst_q != 32'hFFFF_FFFF))                          burst_q <= burst_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
  assign burst_cnt_o = burst_q;
`endif

endmodule

// File: doc/cc_rbeat_serializer.md
Name: cc_rbeat_serializer

Overview:
- Sits in the cache controller directly upstream of the INCT AXI R channel.
- Consumes whole 512-bit cache lines produced by the hit path or the miss-fill path, each tagged with an AXI ID and a critical-word index.
- Emits each line as an 8-beat, 64-bit wrapping burst, critical word first, with rlast on the 8th beat.
- Holds two lines internally so that one line drains while the next is loaded.

Parameters:
- ID_WIDTH, 4, width of line_id_i and inct_rid_o.
- BEAT_WIDTH, 64, R-channel data width.
- LINE_WIDTH, 512, cache line width; BEATS = LINE_WIDTH/BEAT_WIDTH = 8.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- line_valid_i  input  1  producer offers a line.
- line_ready_o  output  1  serializer can accept a line.
- line_id_i  input  ID_WIDTH  AXI ID of the request.
- line_ofs_i  input  3  critical 64-bit word index (address bits [5:3]).
- line_data_i  input  LINE_WIDTH  line data; word k = bits [64k+63:64k].
- inct_rid_o  output  ID_WIDTH  R-channel ID.
- inct_rdata_o  output  BEAT_WIDTH  R-channel data.
- inct_rresp_o  output  2  always 2'b00 (OKAY).
- inct_rlast_o  output  1  final beat of burst.
- inct_rvalid_o  output  1  beat valid.
- inct_rready_i  input  1  consumer accepts beat.

Behaviour:
- Reset (rst_n low, asynchronous): occupancy=0, beat counter=0, head pointer=0, tail pointer=0, line_ready_o=0. All R outputs are 0. Stored line contents are don't-care.
- Reset deasserted mid-burst: the partial burst is discarded; no further beats of it are sent.
- line_ready_o is registered. It is 1 when the next occupancy is < 2. It rises in the first clk edge after rst_n deasserts.
- Push: occurs on the clk edge where line_valid_i && line_ready_o. Stores {id, ofs, data} at the tail and increments the tail mod 2.
- Pop: occurs on the last-beat handshake. Increments the head mod 2 and resets the beat counter to 0.
- No push is possible when full; ready is 0 at occupancy 2. Push and pop in the same cycle at occupancy 1 leaves occupancy at 1.
- Latency: a line accepted at edge N into an empty buffer gives inct_rvalid_o=1 after edge N; no bypass.
- inct_rvalid_o = (occupancy != 0).
- Beat selection: beat counter cnt runs 0..7. Word index = (head.ofs + cnt) mod 8, a 3-bit wrap. inct_rdata_o = head word[index].
- inct_rid_o = head.id. inct_rlast_o = (cnt==7) && inct_rvalid_o.
- Beat handshake = inct_rvalid_o && inct_rready_i. On a handshake, cnt increments; on the handshake with cnt=7, pop.
- AXI stability: while inct_rvalid_o=1 and inct_rready_i=0, rid/rdata/rlast/rresp hold constant. A push in that cycle writes only the non-head slot.
- Back-to-back lines: beat 0 of the next line is presented in the cycle after the previous rlast handshake. Full throughput is 8 beats per 8 cycles.
- With inct_rready_i held low indefinitely: at most 2 lines accepted, then line_ready_o=0.

Optional Feature:
- Macro: CC_RBEAT_PERF_EN.
- Defined:
  - Adds output ports stall_cnt_o[31:0] and burst_cnt_o[31:0].
  - stall_cnt_o counts cycles with rvalid && !rready. burst_cnt_o counts rlast handshakes.
  - Both saturate at 32'hFFFF_FFFF, reset to 0 asynchronously, and are readable via the APB register block.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cc_pkg holds:
  - CC_LINE_W=512, CC_BEAT_W=64, CC_BEATS=8, CC_ID_W=4.
  - localparam RRESP_OKAY=2'b00.
  - typedef cc_line_entry_t {id, ofs[2:0], data[511:0]}.
- Sub-module cc_line_buf: 2-entry FIFO of cc_line_entry_t with push/pop/full/empty and head read. The serializer adds the beat counter, wrap mux and R-channel logic.

Test Plan:
- Single line, id=4'h3, ofs=5, word k = 64'h1111_0000_0000_000k, rready=1:
  - beats are words 5,6,7,0,1,2,3,4 on consecutive cycles;
  - rid=3 and rresp=0 on every beat;
  - rlast only on word 4;
  - rvalid drops the cycle after.
- ofs=0 and ofs=7: order 0..7 and 7,0..6 respectively; exactly 8 beats; rlast on the 8th.
- Backpressure: rready toggles 1,0,0,1 repeating while two lines are offered:
  - rdata/rid/rlast stable during stall cycles;
  - third line offered sees line_ready_o=0 until the first rlast handshake.
- Back-to-back: three lines ids 1,2,3 with rready=1 give 24 consecutive valid beats, no bubble, rlast at beats 8, 16 and 24.
- Async reset asserted after beat 3 of a burst:
  - all outputs are 0 immediately;
  - after release, a new line (id=5, ofs=2) bursts cleanly starting at word 2.
- CC_RBEAT_PERF_EN build: a 2-line run with 6 total stall cycles gives stall_cnt_o=6 and burst_cnt_o=2.
